// File: rtl/iob_gray_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// iob_gray_fifo_ctrl
//   Single-clock FIFO pointer/flag controller for an external 2^ADDR_W-entry
//   dual-port RAM. Keeps (ADDR_W+1)-bit write/read pointers in binary and
//   Gray form (Gray copies exported for later CDC reuse) and derives
//   full/empty/level plus the RAM write/read strobes and addresses.
//
//   Optional feature macro: IOB_GRAY_FIFO_CTRL_ERR_EN
//     adds sticky overflow/underflow flags (err_clr_i, w_err_o, r_err_o).
//
// Ports
//   clk_i, cke_i, rst_i       clock, clock enable, sync active-high reset
//   w_en_i, r_en_i            write / read requests
//   w_full_o, r_empty_o       registered flags
//   level_o                   occupancy 0..2^ADDR_W
//   ext_mem_w_en_o/_w_addr_o  RAM write strobe (accepted write) and address
//   ext_mem_r_en_o/_r_addr_o  RAM read strobe (accepted read) and address
//   w_ptr_gray_o, r_ptr_gray_o registered Gray pointers
// ---------------------------------------------------------------------------
module iob_gray_fifo_ctrl #(
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic              w_en_i,
    input  logic              r_en_i,
`ifdef IOB_GRAY_FIFO_CTRL_ERR_EN
    input  logic              err_clr_i,
    output logic              w_err_o,
    output logic              r_err_o,
`endif
    output logic              w_full_o,
    output logic              r_empty_o,
    output logic [ADDR_W:0]   level_o,
    output logic              ext_mem_w_en_o,
    output logic [ADDR_W-1:0] ext_mem_w_addr_o,
    output logic              ext_mem_r_en_o,
    output logic [ADDR_W-1:0] ext_mem_r_addr_o,
    output logic [ADDR_W:0]   w_ptr_gray_o,
    output logic [ADDR_W:0]   r_ptr_gray_o
);

    // Full when the Gray pointers differ in exactly the top two bits.
    // For ADDR_W=1 this pattern is 2'b11 and covers the whole pointer.
    localparam logic [ADDR_W:0] FULL_XOR = (ADDR_W+1)'(3) << (ADDR_W-1);

    logic [ADDR_W:0] w_bin_q,  w_bin_d,  r_bin_q,  r_bin_d;
    logic [ADDR_W:0] w_gray_q, w_gray_d, r_gray_q, r_gray_d;
    logic [ADDR_W:0] level_q,  level_d;
    logic            full_q,   full_d,   empty_q,  empty_d;

    logic            w_acc, r_acc;
    logic [ADDR_W:0] w_bin_nxt, r_bin_nxt, w_gray_nxt, r_gray_nxt;

    always_comb begin
        w_acc      = w_en_i & ~full_q;
        r_acc      = r_en_i & ~empty_q;
        w_bin_nxt  = w_bin_q + {{ADDR_W{1'b0}}, w_acc};
        r_bin_nxt  = r_bin_q + {{ADDR_W{1'b0}}, r_acc};
        w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);
        r_gray_nxt = r_bin_nxt ^ (r_bin_nxt >> 1);

        w_bin_d  = w_bin_nxt;
        r_bin_d  = r_bin_nxt;
        w_gray_d = w_gray_nxt;
        r_gray_d = r_gray_nxt;
        empty_d  = (r_gray_nxt == w_gray_nxt);
        full_d   = ((w_gray_nxt ^ r_gray_nxt) == FULL_XOR);
        level_d  = w_bin_nxt - r_bin_nxt;

        // Reset overrides state only; the strobes above still follow inputs.
        if (rst_i) begin
            w_bin_d  = '0;
            r_bin_d  = '0;
            w_gray_d = '0;
            r_gray_d = '0;
            empty_d  = 1'b1;
            full_d   = 1'b0;
            level_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            w_bin_q  <= w_bin_d;
            r_bin_q  <= r_bin_d;
            w_gray_q <= w_gray_d;
            r_gray_q <= r_gray_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            level_q  <= level_d;
        end
    end

`ifdef IOB_GRAY_FIFO_CTRL_ERR_EN
    logic w_err_q, w_err_d, r_err_q, r_err_d;

    // Sticky; a new violation wins over a same-cycle clear, reset wins over all.
    always_comb begin
        w_err_d = w_err_q;
        r_err_d = r_err_q;
        if (err_clr_i) begin
            w_err_d = 1'b0;
            r_err_d = 1'b0;
        end
        if (w_en_i & full_q)  w_err_d = 1'b1;
        if (r_en_i & empty_q) r_err_d = 1'b1;
        if (rst_i) begin
            w_err_d = 1'b0;
            r_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            w_err_q <= w_err_d;
            r_err_q <= r_err_d;
        end
    end

    assign w_err_o = w_err_q;
    assign r_err_o = r_err_q;
`endif

    assign w_full_o         = full_q;
    assign r_empty_o        = empty_q;
    assign level_o          = level_q;
    assign ext_mem_w_en_o   = w_acc;
    assign ext_mem_r_en_o   = r_acc;
    assign ext_mem_w_addr_o = w_bin_q[ADDR_W-1:0];
    assign ext_mem_r_addr_o = r_bin_q[ADDR_W-1:0];
    assign w_ptr_gray_o     = w_gray_q;
    assign r_ptr_gray_o     = r_gray_q;

endmodule

// File: tb/tb_iob_gray_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iob_gray_fifo_ctrl
//   Scoreboard bench for iob_gray_fifo_ctrl at ADDR_W=2 (depth 4).
//   The driver applies one request per cycle, computes the expected outputs
//   for that cycle from an occupancy/transfer-count model and queues them;
//   a monitor on the falling edge pops each entry and compares.
// ---------------------------------------------------------------------------
module tb_iob_gray_fifo_ctrl;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          cke, rst, w_en, r_en;
    logic          w_full, r_empty, mw_en, mr_en;
    logic [AW:0]   level, wg, rg;
    logic [AW-1:0] mw_addr, mr_addr;
`ifdef IOB_GRAY_FIFO_CTRL_ERR_EN
    logic          err_clr, w_err, r_err;
`endif

    iob_gray_fifo_ctrl #(.ADDR_W(AW)) dut (
        .clk_i            (clk),
        .cke_i            (cke),
        .rst_i            (rst),
        .w_en_i           (w_en),
        .r_en_i           (r_en),
`ifdef IOB_GRAY_FIFO_CTRL_ERR_EN
        .err_clr_i        (err_clr),
        .w_err_o          (w_err),
        .r_err_o          (r_err),
`endif
        .w_full_o         (w_full),
        .r_empty_o        (r_empty),
        .level_o          (level),
        .ext_mem_w_en_o   (mw_en),
        .ext_mem_w_addr_o (mw_addr),
        .ext_mem_r_en_o   (mr_en),
        .ext_mem_r_addr_o (mr_addr),
        .w_ptr_gray_o     (wg),
        .r_ptr_gray_o     (rg)
    );

    always #5 clk = ~clk;

    typedef struct {
        int  we, re, wa, ra, full, empty, lvl, wg, rg;
        bit  wstep, rstep;
        int  werr, rerr;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: occupancy plus total accepted writes/reads since reset.
    int count = 0, wcnt = 0, rcnt = 0;
    int m_werr = 0, m_rerr = 0;
    bit last_wmove = 0, last_rmove = 0;

    function automatic int gray(input int n);
        int b;
        b = n % (2 * DEPTH);
        return b ^ (b >> 1);
    endfunction

    task automatic step(input bit w, input bit r, input bit rs, input bit ck,
                        input bit clr);
        exp_t e;
        bit   wa, ra;
        @(posedge clk);
        #1;
        w_en = w; r_en = r; rst = rs; cke = ck;
`ifdef IOB_GRAY_FIFO_CTRL_ERR_EN
        err_clr = clr;
`endif
        wa = w && (count < DEPTH);
        ra = r && (count > 0);
        e.we = wa; e.re = ra;
        e.wa = wcnt % DEPTH; e.ra = rcnt % DEPTH;
        e.full = (count == DEPTH); e.empty = (count == 0);
        e.lvl = count; e.wg = gray(wcnt); e.rg = gray(rcnt);
        e.wstep = last_wmove; e.rstep = last_rmove;
        e.werr = m_werr; e.rerr = m_rerr;
        exp_q.push_back(e);
        last_wmove = 0; last_rmove = 0;
        if (ck) begin
            if (rs) begin
                count = 0; wcnt = 0; rcnt = 0; m_werr = 0; m_rerr = 0;
            end else begin
                count += int'(wa) - int'(ra);
                wcnt  += int'(wa);
                rcnt  += int'(ra);
                last_wmove = wa; last_rmove = ra;
                if (clr) begin m_werr = 0; m_rerr = 0; end
                if (w && !wa) m_werr = 1;
                if (r && !ra) m_rerr = 1;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int expv);
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: one queued expectation per cycle, compared mid-cycle.
    logic [AW:0] prev_wg = '0, prev_rg = '0;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            chk("w_strobe", int'(mw_en),   e.we);
            chk("r_strobe", int'(mr_en),   e.re);
            chk("w_addr",   int'(mw_addr), e.wa);
            chk("r_addr",   int'(mr_addr), e.ra);
            chk("full",     int'(w_full),  e.full);
            chk("empty",    int'(r_empty), e.empty);
            chk("level",    int'(level),   e.lvl);
            chk("w_gray",   int'(wg),      e.wg);
            chk("r_gray",   int'(rg),      e.rg);
            if (e.wstep) chk("w_gray_1bit", $countones(wg ^ prev_wg), 1);
            if (e.rstep) chk("r_gray_1bit", $countones(rg ^ prev_rg), 1);
`ifdef IOB_GRAY_FIFO_CTRL_ERR_EN
            chk("w_err", int'(w_err), e.werr);
            chk("r_err", int'(r_err), e.rerr);
`endif
            prev_wg = wg;
            prev_rg = rg;
        end
    end

    initial begin
        cke = 1'b1; rst = 1'b1; w_en = 1'b0; r_en = 1'b0;
`ifdef IOB_GRAY_FIFO_CTRL_ERR_EN
        err_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);

        step(0, 0, 1, 1, 0);                            // reset state
        repeat (4) step(1, 0, 0, 1, 0);                 // fill: 001,011,010,110
        step(1, 0, 0, 1, 0);                            // write while full
        step(0, 0, 0, 1, 0);
        repeat (4) step(0, 1, 0, 1, 0);                 // drain, addrs 0..3
        step(0, 1, 0, 1, 0);                            // read while empty
        step(0, 0, 0, 1, 1);                            // clear errors
        repeat (2) step(1, 0, 0, 1, 0);                 // level 2
        repeat (10) step(1, 1, 0, 1, 0);                // streaming, wraps
        repeat (2) step(0, 1, 0, 1, 0);                 // back to empty
        step(1, 1, 0, 1, 0);                            // w+r at empty
        repeat (3) step(1, 0, 0, 1, 0);                 // full
        step(1, 1, 0, 1, 0);                            // w+r at full
        step(0, 0, 0, 1, 0);
        repeat (3) step(1, 0, 0, 1, 0);
        step(1, 0, 1, 0, 0);                            // reset gated by cke
        step(1, 1, 0, 0, 0);                            // everything holds
        step(1, 1, 1, 1, 0);                            // reset, strobes live
        step(0, 0, 0, 1, 0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom % 100) < 55, ($urandom % 100) < 50,
                 ($urandom % 64) == 0, ($urandom % 8) != 0,
                 ($urandom % 16) == 0);
        end

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
